// File: rtl/sha3_lane_packer_pkg.sv
// Shared sha3 types: 64-bit lane, 5x5 state geometry and the lane index -> (row, column) mapping.
// Combinational helpers only; no state, no flow control.
package sha3_lane_packer_pkg;

    localparam int MAX_LANES = 25;

    typedef logic [63:0]      lane_t;
    typedef logic [4:0][63:0] row_t;

    typedef enum logic {
        ST_EMPTY   = 1'b0,
        ST_FILLING = 1'b1
    } pack_state_e;

    // Lane k sits at row y = k / 5, column x = k % 5 of the Keccak state.
    function automatic logic [2:0] lane_row(input int k);
        return 3'(k / 5);
    endfunction

    function automatic logic [2:0] lane_col(input int k);
        return 3'(k % 5);
    endfunction

endpackage

// File: rtl/sha3_lane_packer.sv
// Packs a stream of 64-bit lanes into a 5x5 sponge block; os*/good follow the final accept by 1 cycle.
// Double-buffered, so in_ready stays high whenever out of reset: back-to-back blocks need no idle cycle.
module sha3_lane_packer
    import sha3_lane_packer_pkg::*;
#(
    parameter int RATE_LANES     = 17,
    parameter bit IN_LAST_ENABLE = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] in_lane,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output row_t        osa,
    output row_t        osb,
    output row_t        osc,
    output row_t        osd,
    output row_t        ose,
    output logic        good,
    output logic [31:0] blocks
);

    localparam int CW = 5;

    pack_state_e                  state_q, state_d;
    logic        [CW-1:0]         cnt_q, cnt_d;
    lane_t       [MAX_LANES-1:0]  acc_q, acc_d;
    logic        [MAX_LANES-1:0]  mask_q, mask_d;
    row_t        [4:0]            os_q, os_d;
    logic                         good_q, good_d;
    logic        [31:0]           blocks_q, blocks_d;
    logic                         rdy_q;

    logic accept;
    logic last_lane;
    logic final_acc;

    assign accept    = in_valid && rdy_q;
    assign last_lane = (cnt_q == CW'(RATE_LANES - 1));
    assign final_acc = accept && (last_lane || (IN_LAST_ENABLE && in_last));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mask_d   = mask_q;
        os_d     = os_q;
        good_d   = 1'b0;
        blocks_d = blocks_q;

        if (final_acc) begin
            // The final lane bypasses the accumulator; lanes past it (capacity) are zeroed.
            for (int k = 0; k < MAX_LANES; k++) begin
                if (k == int'(cnt_q)) begin
                    os_d[lane_row(k)][lane_col(k)] = in_lane;
                end else if (mask_q[k]) begin
                    os_d[lane_row(k)][lane_col(k)] = acc_q[k];
                end else begin
                    os_d[lane_row(k)][lane_col(k)] = '0;
                end
            end
            mask_d   = '0;
            cnt_d    = '0;
            state_d  = ST_EMPTY;
            good_d   = 1'b1;
            blocks_d = blocks_q + 32'd1;
        end else if (accept) begin
            acc_d[cnt_q]  = in_lane;
            mask_d[cnt_q] = 1'b1;
            cnt_d         = cnt_q + CW'(1);
            state_d       = ST_FILLING;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_EMPTY;
            cnt_q    <= '0;
            acc_q    <= '0;
            mask_q   <= '0;
            os_q     <= '0;
            good_q   <= 1'b0;
            blocks_q <= '0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mask_q   <= mask_d;
            os_q     <= os_d;
            good_q   <= good_d;
            blocks_q <= blocks_d;
            rdy_q    <= 1'b1;
        end
    end

    assign in_ready = rdy_q;
    assign osa      = os_q[0];
    assign osb      = os_q[1];
    assign osc      = os_q[2];
    assign osd      = os_q[3];
    assign ose      = os_q[4];
    assign good     = good_q;
    assign blocks   = blocks_q;

endmodule

// File: tb/tb_sha3_lane_packer.sv
// Randomised bench for sha3_lane_packer: a 17-lane/in_last instance and a 9-lane/no-in_last instance
// run side by side against a block-list reference model, plus directed block scenarios.
module tb_sha3_lane_packer;
    import sha3_lane_packer_pkg::*;

    logic  clk = 1'b0;
    logic  rst = 1'b0;
    logic  v0 = 1'b0, l0 = 1'b0, v1 = 1'b0, l1 = 1'b0;
    lane_t d0 = '0, d1 = '0;

    logic        rdy0, rdy1, g0, g1;
    row_t        a0, b0, c0, dd0, e0;
    row_t        a1, b1, c1, dd1, e1;
    logic [31:0] bk0, bk1;

    sha3_lane_packer #(.RATE_LANES(17), .IN_LAST_ENABLE(1'b1)) dut0 (
        .clk(clk), .rst(rst), .in_lane(d0), .in_valid(v0), .in_last(l0), .in_ready(rdy0),
        .osa(a0), .osb(b0), .osc(c0), .osd(dd0), .ose(e0), .good(g0), .blocks(bk0)
    );

    sha3_lane_packer #(.RATE_LANES(9), .IN_LAST_ENABLE(1'b0)) dut1 (
        .clk(clk), .rst(rst), .in_lane(d1), .in_valid(v1), .in_last(l1), .in_ready(rdy1),
        .osa(a1), .osb(b1), .osc(c1), .osd(dd1), .ose(e1), .good(g1), .blocks(bk1)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int g1cnt  = 0;
    int good_cyc0[$];

    // Reference model: the lanes of the open block, and the last emitted block laid out by lane index.
    lane_t       mblk  [2][25];
    int          mcnt  [2];
    lane_t       mos   [2][25];
    logic        mgood [2];
    logic [31:0] mblocks [2];
    logic        mrdy;
    int          mrate [2] = '{17, 9};
    bit          men   [2] = '{1'b1, 1'b0};

    lane_t la [3];
    lane_t gl [9];
    int    gap;

    task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, obs, exp);
    endtask

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 25; k++) begin
                mos[d][k]  = '0;
                mblk[d][k] = '0;
            end
            mcnt[d]    = 0;
            mgood[d]   = 1'b0;
            mblocks[d] = '0;
        end
        mrdy = 1'b0;
    endfunction

    function automatic void mstep(input int d, input logic v, input logic l, input lane_t dat);
        if (v) begin
            mblk[d][mcnt[d]] = dat;
            mcnt[d]++;
            if (mcnt[d] == mrate[d] || (l && men[d])) begin
                for (int k = 0; k < 25; k++) mos[d][k] = (k < mcnt[d]) ? mblk[d][k] : '0;
                mgood[d] = 1'b1;
                mblocks[d]++;
                mcnt[d] = 0;
            end
        end
    endfunction

    function automatic logic [319:0] exp_row(input int d, input int y);
        logic [319:0] r;
        r = '0;
        for (int x = 0; x < 5; x++) r[64*x +: 64] = mos[d][5*y + x];
        return r;
    endfunction

    task automatic check_all();
        row_t r0 [5];
        row_t r1 [5];
        r0 = '{a0, b0, c0, dd0, e0};
        r1 = '{a1, b1, c1, dd1, e1};
        chk("ready0",  320'(rdy0), 320'(mrdy));
        chk("ready1",  320'(rdy1), 320'(mrdy));
        chk("good0",   320'(g0),   320'(mgood[0]));
        chk("good1",   320'(g1),   320'(mgood[1]));
        chk("blocks0", 320'(bk0),  320'(mblocks[0]));
        chk("blocks1", 320'(bk1),  320'(mblocks[1]));
        for (int y = 0; y < 5; y++) begin
            chk($sformatf("row%0d_dut0", y), r0[y], exp_row(0, y));
            chk($sformatf("row%0d_dut1", y), r1[y], exp_row(1, y));
        end
    endtask

    task automatic tick();
        logic was_rdy;
        @(posedge clk);
        #1;
        cyc++;
        was_rdy  = mrdy;
        mgood[0] = 1'b0;
        mgood[1] = 1'b0;
        if (rst) begin
            if (was_rdy) begin
                mstep(0, v0, l0, d0);
                mstep(1, v1, l1, d1);
            end
            mrdy = 1'b1;
        end
        if (g0) good_cyc0.push_back(cyc);
        if (g1) g1cnt++;
        check_all();
    endtask

    function automatic lane_t rnd_lane();
        return {$urandom, $urandom};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $display("%0d/%0d checks passed", n_pass, n_chk + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();

        // Reset state, then in_ready rises only at the first edge after release.
        rst = 1'b0;
        v0 = 1'b1; d0 = rnd_lane();
        repeat (3) tick();
        v0 = 1'b0;
        #2 rst = 1'b1;
        #1 chk("ready_before_edge", 320'(rdy0), 320'(1'b0));
        tick();

        // Full 17-lane block, lanes 1..17.
        for (int k = 0; k < 17; k++) begin
            v0 = 1'b1; d0 = 64'(k + 1); l0 = 1'b0;
            tick();
        end
        v0 = 1'b0;
        chk("full_osa",    a0,  {64'd5, 64'd4, 64'd3, 64'd2, 64'd1});
        chk("full_osd",    dd0, {64'd0, 64'd0, 64'd0, 64'd17, 64'd16});
        chk("full_ose",    e0,  320'd0);
        chk("full_blocks", 320'(bk0), 320'(32'd1));
        chk("full_good",   320'(g0),  320'(1'b1));
        tick();

        // Early end on the third lane.
        for (int i = 0; i < 3; i++) begin
            la[i] = rnd_lane();
            v0 = 1'b1; d0 = la[i]; l0 = (i == 2);
            tick();
        end
        v0 = 1'b0; l0 = 1'b0;
        chk("early_osa", a0, {64'd0, 64'd0, la[2], la[1], la[0]});
        chk("early_osb", b0, 320'd0);
        tick();

        // Two back-to-back 17-lane blocks.
        good_cyc0.delete();
        for (int i = 0; i < 34; i++) begin
            v0 = 1'b1; d0 = rnd_lane(); l0 = 1'b0;
            tick();
        end
        v0 = 1'b0;
        repeat (3) tick();
        gap = (good_cyc0.size() >= 2) ? good_cyc0[1] - good_cyc0[0] : -1;
        chk("b2b_pulses", 320'(good_cyc0.size()), 320'(2));
        chk("b2b_gap",    320'(gap), 320'(17));

        // 9-lane block with in_valid toggling; in_last is noise on this instance.
        g1cnt = 0;
        for (int i = 0; i < 9; i++) gl[i] = rnd_lane();
        for (int i = 0; i < 17; i++) begin
            v1 = (i % 2 == 0);
            d1 = v1 ? gl[i/2] : rnd_lane();
            l1 = 1'($urandom_range(0, 1));
            tick();
        end
        v1 = 1'b0; l1 = 1'b0;
        chk("gap_osa",    a1, {gl[4], gl[3], gl[2], gl[1], gl[0]});
        chk("gap_osb",    b1, {64'd0, gl[8], gl[7], gl[6], gl[5]});
        repeat (2) tick();
        chk("gap_pulses", 320'(g1cnt), 320'(1));

        // Reset in the middle of a block.
        for (int i = 0; i < 5; i++) begin
            v0 = 1'b1; d0 = rnd_lane();
            tick();
        end
        v0 = 1'b0;
        #2 rst = 1'b0;
        #1 model_reset();
        check_all();
        repeat (2) tick();
        #2 rst = 1'b1;
        tick();
        good_cyc0.delete();
        for (int i = 0; i < 17; i++) begin
            v0 = 1'b1; d0 = rnd_lane(); l0 = 1'b0;
            tick();
        end
        v0 = 1'b0;
        chk("rst_blocks", 320'(bk0), 320'(32'd1));
        chk("rst_pulses", 320'(good_cyc0.size()), 320'(1));
        tick();

        // Random traffic on both instances.
        for (int i = 0; i < 400; i++) begin
            v0 = ($urandom_range(0, 3) != 0); l0 = ($urandom_range(0, 5) == 0); d0 = rnd_lane();
            v1 = ($urandom_range(0, 3) != 0); l1 = ($urandom_range(0, 1) == 0); d1 = rnd_lane();
            tick();
        end
        v0 = 1'b0; v1 = 1'b0; l0 = 1'b0; l1 = 1'b0;
        tick();

        // Block counter wrap.
        force dut0.blocks_q = 32'hFFFF_FFFF;
        #1 release dut0.blocks_q;
        mblocks[0] = 32'hFFFF_FFFF;
        #1 chk("wrap_preset", 320'(bk0), 320'(32'hFFFF_FFFF));
        for (int i = 0; i < 17; i++) begin
            v0 = 1'b1; d0 = rnd_lane(); l0 = 1'b0;
            tick();
        end
        v0 = 1'b0;
        chk("wrap_blocks", 320'(bk0), 320'(32'd0));
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sha3_lane_packer.md
SHA3_LANE_PACKER -- requirements
Module: sha3_lane_packer

Interface
REQ-001 SHALL have parameter RATE_LANES, default 17, the lanes per absorbed block (legal 1..25; SHA3-256 = 17, SHA3-512 = 9).
REQ-002 SHALL have parameter IN_LAST_ENABLE, default 1; when 1, in_last may end a block early.
REQ-003 SHALL have port clk, input, 1, the single clock; all state is on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port in_lane, input, 64, the lane being offered.
REQ-006 SHALL have port in_valid, input, 1, meaning in_lane is offered this cycle.
REQ-007 SHALL have port in_last, input, 1, meaning the offered lane ends the block (qualified by in_valid).
REQ-008 SHALL have port in_ready, output, 1, meaning the packer accepts a lane this cycle.
REQ-009 SHALL have ports osa, osb, osc, osd, ose, output, 5x64 each, rows y=0..4 of the packed state; element [x] is lane x+5y.
REQ-010 SHALL have port good, output, 1, a one-cycle strobe marking os* valid; it drives the round's sample input.
REQ-011 SHALL have port blocks, output, 32, the count of emitted blocks.

Function
REQ-012 SHALL accept a lane on every cycle where in_valid && in_ready ("accept").
REQ-013 SHALL store accepted lane number k (0-based within the block) at lane index k of the accumulation matrix.
REQ-014 SHALL hold lane counter cnt in range 0..RATE_LANES-1, incrementing on each accept.
REQ-015 SHALL make an accept "final" when cnt == RATE_LANES-1, or when in_last == 1 and IN_LAST_ENABLE == 1.
REQ-016 On a final accept at cycle t, SHALL load os* at edge t+1 with the accumulated lanes 0..k-1 plus the final lane at index k, and zero in every lane index > k (capacity and unfilled lanes).
REQ-017 SHALL assert good for exactly cycle t+1 following a final accept; good SHALL be low otherwise.
REQ-018 SHALL reset cnt to 0 on a final accept, and SHALL clear the accumulation valid-mask.
REQ-019 SHALL hold os* stable from one load until the next final accept, independent of accumulation writes.
REQ-020 SHALL be double-buffered (accumulation register plus output register) so that in_ready == 1 whenever rst is deasserted; back-to-back blocks therefore need no idle cycle.
REQ-021 SHALL use states EMPTY (cnt == 0) and FILLING (cnt > 0).
  - EMPTY -> FILLING on a non-final accept.
  - FILLING -> EMPTY on a final accept.
  - EMPTY -> EMPTY on a final accept of a block that is one lane long.
REQ-022 SHALL ignore in_last while IN_LAST_ENABLE == 0; the block then ends only at RATE_LANES.
REQ-023 SHALL increment blocks by 1 on each good pulse, wrapping from 2^32-1 to 0.
REQ-024 SHALL ignore in_lane, in_last and lane contents when in_valid == 0; cnt and state are then unchanged.
REQ-025 SHALL have a latency of 1 cycle from final accept to good.

Reset
REQ-026 While rst == 0, SHALL force cnt = 0, state = EMPTY, good = 0, in_ready = 0, blocks = 0, and every os* lane and accumulation lane to 0.
REQ-027 A reset mid-block SHALL discard the partial block; no good pulse SHALL follow reset.
REQ-028 in_ready SHALL rise on the first clk edge after rst deasserts.

Structure
REQ-029 SHALL place the lane-index mapping function (k -> row, column), the 64-bit lane type, and the constant MAX_LANES = 25 in the shared sha3 package.
REQ-030 SHALL be a single module with no sub-modules; the output matrix SHALL connect directly to sha3_5x5_pipelined_round.

Verification
REQ-031 Full block: RATE_LANES = 17, lanes 1..17 sent back-to-back -> good one cycle after lane 17; osa = {1,2,3,4,5}, osd[1] = 17, osd[2..4] = 0, ose all 0; blocks = 1.
REQ-032 Early end: in_last on the 3rd lane (values A, B, C) -> osa = {A,B,C,0,0}, all other rows 0; the next block starts at lane index 0.
REQ-033 Back-to-back: two 17-lane blocks with no gap -> two good pulses 17 cycles apart; block-1 os* values stay stable until the block-2 load.
REQ-034 Gaps: in_valid toggled 1,0,1,0 across a 9-lane block (RATE_LANES = 9) -> contents are identical to the gap-free case and good rises once.
REQ-035 Reset mid-block: rst pulled low after 5 lanes -> all outputs 0, no good; the next 17 lanes produce a correct block with blocks = 1.
REQ-036 Counter wrap: blocks preset by force to 0xFFFFFFFF, then one block sent -> blocks = 0.
